// File: rtl/alert_scheduler.sv
// Alert scheduler: latches rising-edge alerts, announces the highest priority
// one on a shared buzzer, retries until acknowledged and escalates if unanswered.
module alert_scheduler #(
    parameter int unsigned BEEP_CYCLES = 50,
    parameter int unsigned ACK_TIMEOUT = 200,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fall_state,
    input  logic       bpm_state,
    input  logic       temp_state,
    input  logic       medicine_reminder,
    input  logic       ack,
    output logic       buzzer,
    output logic [3:0] active_alert,
    output logic [3:0] pending,
    output logic       escalate,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ANNOUNCE,
        WAIT_ACK,
        ESCALATE
    } state_e;

    localparam logic [15:0] BEEP_LOAD = 16'(BEEP_CYCLES - 1);
    localparam logic [15:0] ACK_LOAD  = 16'(ACK_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [3:0]  prev_q, prev_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  active_q, active_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic        buzzer_q, buzzer_d;
    logic        escalate_q, escalate_d;
    logic        busy_q, busy_d;

    logic [3:0]  alerts;
    logic [3:0]  rise;
    logic [3:0]  pick;
    logic [3:0]  clear;
    logic [3:0]  retry_inc;
    logic        preempt;

    always_comb begin
        alerts    = {medicine_reminder, temp_state,
                     bpm_state, fall_state};
        rise      = alerts & ~prev_q;
        // Lowest set bit is the highest-priority pending alert.
        pick      = pending_q & (~pending_q + 4'd1);
        retry_inc = retry_q + 4'd1;
        preempt   = rise[0] && !active_q[0];

        prev_d   = alerts;
        state_d  = state_q;
        active_d = active_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        clear    = 4'b0000;

        unique case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d  = ANNOUNCE;
                    active_d = pick;
                    retry_d  = 4'd0;
                    timer_d  = BEEP_LOAD;
                end
            end
            ANNOUNCE: begin
                if (ack) begin
                    clear    = active_q;
                    active_d = 4'b0000;
                    retry_d  = 4'd0;
                    timer_d  = 16'd0;
                    state_d  = IDLE;
                end else if (preempt) begin
                    active_d = 4'b0000;
                    retry_d  = 4'd0;
                    timer_d  = 16'd0;
                    state_d  = IDLE;
                end else if (timer_q != 16'd0) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    timer_d = ACK_LOAD;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    clear    = active_q;
                    active_d = 4'b0000;
                    retry_d  = 4'd0;
                    timer_d  = 16'd0;
                    state_d  = IDLE;
                end else if (preempt) begin
                    active_d = 4'b0000;
                    retry_d  = 4'd0;
                    timer_d  = 16'd0;
                    state_d  = IDLE;
                end else if (timer_q != 16'd0) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_LIM) begin
                        timer_d = 16'd0;
                        state_d = ESCALATE;
                    end else begin
                        timer_d = BEEP_LOAD;
                        state_d = ANNOUNCE;
                    end
                end
            end
            ESCALATE: begin
                if (ack) begin
                    clear    = active_q;
                    active_d = 4'b0000;
                    retry_d  = 4'd0;
                    timer_d  = 16'd0;
                    state_d  = IDLE;
                end
            end
        endcase

        // A fresh edge on the source being cleared keeps it pending.
        pending_d  = (pending_q & ~clear) | rise;
        buzzer_d   = (state_d == ANNOUNCE) ||
                     (state_d == ESCALATE);
        escalate_d = (state_d == ESCALATE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= 4'b0000;
            pending_q  <= 4'b0000;
            active_q   <= 4'b0000;
            timer_q    <= 16'd0;
            retry_q    <= 4'd0;
            buzzer_q   <= 1'b0;
            escalate_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            buzzer_q   <= buzzer_d;
            escalate_q <= escalate_d;
            busy_q     <= busy_d;
        end
    end

    assign buzzer       = buzzer_q;
    assign active_alert = active_q;
    assign pending      = pending_q;
    assign escalate     = escalate_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alert_scheduler.sv
// Scoreboard bench for alert_scheduler: expected output runs (value, length)
// are queued by the stimulus and popped by a monitor on every output change.
module tb_alert_scheduler;

    typedef struct packed {
        logic       busy;
        logic       buzzer;
        logic       escalate;
        logic [3:0] active;
        logic [3:0] pending;
    } obs_t;

    typedef struct packed {
        obs_t o;
        int   len;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fall_state = 1'b0;
    logic       bpm_state = 1'b0;
    logic       temp_state = 1'b0;
    logic       medicine_reminder = 1'b0;
    logic       ack = 1'b0;
    logic       buzzer;
    logic [3:0] active_alert;
    logic [3:0] pending;
    logic       escalate;
    logic       busy;

    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    bit   have = 1'b0;
    obs_t prev_obs;
    obs_t cur_obs;
    int   run_len = 0;
    exp_t q[$];

    alert_scheduler #(
        .BEEP_CYCLES(4),
        .ACK_TIMEOUT(8),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fall_state(fall_state),
        .bpm_state(bpm_state),
        .temp_state(temp_state),
        .medicine_reminder(medicine_reminder),
        .ack(ack),
        .buzzer(buzzer),
        .active_alert(active_alert),
        .pending(pending),
        .escalate(escalate),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic b, input logic bz,
                                input logic e, input logic [3:0] a,
                                input logic [3:0] p);
        obs_t o;
        o.busy = b;
        o.buzzer = bz;
        o.escalate = e;
        o.active = a;
        o.pending = p;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(busy, buzzer, escalate, active_alert, pending);
    endfunction

    task automatic expect_run(input obs_t o, input int len);
        exp_t e;
        e.o = o;
        e.len = len;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input obs_t o, input int len);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL run: unexpected obs=%h len=%0d", o, len);
        end else begin
            e = q.pop_front();
            if (e.o != o || (e.len != 0 && e.len != len)) begin
                bad++;
                $display("FAIL run: got obs=%h len=%0d want obs=%h len=%0d",
                         o, len, e.o, e.len);
            end
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if (sample() != '0) begin
            bad++;
            $display("FAIL %s: got obs=%h want 0", name, sample());
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++)
            @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected runs never seen, want 0",
                     name, q.size());
            q.delete();
        end
        tick(2);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur_obs = sample();
            if (!have) begin
                prev_obs = cur_obs;
                run_len = 1;
                have = 1'b1;
            end else if (cur_obs == prev_obs) begin
                run_len++;
            end else begin
                check_run(prev_obs, run_len);
                prev_obs = cur_obs;
                run_len = 1;
            end
        end
    end

    initial begin
        tick(3);
        check_zero("reset_state");
        reset = 1'b0;
        mon_en = 1'b1;

        // temp, ack in second WAIT_ACK cycle
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0000), 0);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0100), 1);
        expect_run(mk(1, 1, 0, 4'b0100, 4'b0100), 4);
        expect_run(mk(1, 0, 0, 4'b0100, 4'b0100), 2);
        tick(1);
        temp_state = 1'b1;
        tick(1);
        temp_state = 1'b0;
        tick(6);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        drain("temp_ack");

        // medicine, no ack: two rounds then escalate
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0000), 0);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b1000), 1);
        expect_run(mk(1, 1, 0, 4'b1000, 4'b1000), 4);
        expect_run(mk(1, 0, 0, 4'b1000, 4'b1000), 8);
        expect_run(mk(1, 1, 0, 4'b1000, 4'b1000), 4);
        expect_run(mk(1, 0, 0, 4'b1000, 4'b1000), 8);
        expect_run(mk(1, 1, 1, 4'b1000, 4'b1000), 5);
        tick(1);
        medicine_reminder = 1'b1;
        tick(1);
        medicine_reminder = 1'b0;
        tick(29);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        drain("med_escalate");

        // bpm and medicine together: bpm first
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0000), 0);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b1010), 1);
        expect_run(mk(1, 1, 0, 4'b0010, 4'b1010), 2);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b1000), 1);
        expect_run(mk(1, 1, 0, 4'b1000, 4'b1000), 4);
        expect_run(mk(1, 0, 0, 4'b1000, 4'b1000), 1);
        tick(1);
        bpm_state = 1'b1;
        medicine_reminder = 1'b1;
        tick(1);
        bpm_state = 1'b0;
        medicine_reminder = 1'b0;
        tick(2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(5);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        drain("priority");

        // fall preempts medicine in WAIT_ACK
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0000), 0);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b1000), 1);
        expect_run(mk(1, 1, 0, 4'b1000, 4'b1000), 4);
        expect_run(mk(1, 0, 0, 4'b1000, 4'b1000), 2);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b1001), 1);
        expect_run(mk(1, 1, 0, 4'b0001, 4'b1001), 2);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b1000), 1);
        expect_run(mk(1, 1, 0, 4'b1000, 4'b1000), 1);
        tick(1);
        medicine_reminder = 1'b1;
        tick(1);
        medicine_reminder = 1'b0;
        tick(6);
        fall_state = 1'b1;
        tick(1);
        fall_state = 1'b0;
        tick(2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        drain("preempt");

        // fall during ESCALATE does not preempt
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0000), 0);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0100), 1);
        expect_run(mk(1, 1, 0, 4'b0100, 4'b0100), 4);
        expect_run(mk(1, 0, 0, 4'b0100, 4'b0100), 8);
        expect_run(mk(1, 1, 0, 4'b0100, 4'b0100), 4);
        expect_run(mk(1, 0, 0, 4'b0100, 4'b0100), 8);
        expect_run(mk(1, 1, 1, 4'b0100, 4'b0100), 2);
        expect_run(mk(1, 1, 1, 4'b0100, 4'b0101), 3);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0001), 1);
        expect_run(mk(1, 1, 0, 4'b0001, 4'b0001), 2);
        tick(1);
        temp_state = 1'b1;
        tick(1);
        temp_state = 1'b0;
        tick(26);
        fall_state = 1'b1;
        tick(1);
        fall_state = 1'b0;
        tick(2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        drain("esc_no_preempt");

        // edge and ack on active source together: stays pending
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0000), 0);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0100), 1);
        expect_run(mk(1, 1, 0, 4'b0100, 4'b0100), 2);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0100), 1);
        expect_run(mk(1, 1, 0, 4'b0100, 4'b0100), 1);
        tick(1);
        temp_state = 1'b1;
        tick(1);
        temp_state = 1'b0;
        tick(2);
        temp_state = 1'b1;
        ack = 1'b1;
        tick(1);
        temp_state = 1'b0;
        ack = 1'b0;
        tick(1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        drain("set_wins");

        // async reset during ANNOUNCE
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0000), 0);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0110), 1);
        expect_run(mk(1, 1, 0, 4'b0010, 4'b0110), 1);
        tick(1);
        bpm_state = 1'b1;
        temp_state = 1'b1;
        tick(1);
        bpm_state = 1'b0;
        temp_state = 1'b0;
        tick(2);
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        tick(2);
        reset = 1'b0;
        tick(5);
        check_zero("idle_after_reset");
        drain("reset_abort");

        // input held high across reset release
        expect_run(mk(0, 0, 0, 4'b0000, 4'b0000), 0);
        expect_run(mk(0, 0, 0, 4'b0000, 4'b1000), 1);
        expect_run(mk(1, 1, 0, 4'b1000, 4'b1000), 2);
        tick(1);
        reset = 1'b1;
        medicine_reminder = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        medicine_reminder = 1'b0;
        drain("held_over_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alert_scheduler.md
ALERT_SCHEDULER -- requirements
Module: alert_scheduler

Interface
REQ-001 SHALL have parameter BEEP_CYCLES, default 50, buzzer-on cycles per announcement (1..65535).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 200, cycles waited for caregiver ack after each announcement (1..65535).
REQ-003 SHALL have parameter MAX_RETRY, default 3, unacked announcements before escalation (1..15).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port fall_state  input  1  fall alert level, priority 0 (highest).
REQ-007 SHALL have port bpm_state  input  1  heart-rate alert level, priority 1.
REQ-008 SHALL have port temp_state  input  1  temperature alert level, priority 2.
REQ-009 SHALL have port medicine_reminder  input  1  reminder level, priority 3 (lowest).
REQ-010 SHALL have port ack  input  1  caregiver acknowledge, sampled each cycle.
REQ-011 SHALL have port buzzer  output  1  shared annunciator drive.
REQ-012 SHALL have port active_alert  output  4  one-hot alert being served; bit0 fall, bit1 bpm, bit2 temp, bit3 medicine; 0 when none.
REQ-013 SHALL have port pending  output  4  latched unacknowledged alerts, same bit order.
REQ-014 SHALL have port escalate  output  1  emergency-call request.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL detect a rising edge on each alert input against a registered copy of that input; edge in cycle n sets its pending bit, visible in cycle n+1.
REQ-017 SHALL hold a pending bit set until its alert is acknowledged while active; input falling does not clear it.
REQ-018 SHALL implement states IDLE, ANNOUNCE, WAIT_ACK, ESCALATE.
REQ-019 IDLE: if pending nonzero, SHALL latch the highest-priority pending bit into active_alert, clear retry count, enter ANNOUNCE next cycle; else stay.
REQ-020 ANNOUNCE: buzzer SHALL be high for exactly BEEP_CYCLES cycles, then enter WAIT_ACK.
REQ-021 WAIT_ACK: buzzer low; timer counts ACK_TIMEOUT cycles; on expiry retry count increments; if new count equals MAX_RETRY enter ESCALATE, else re-enter ANNOUNCE.
REQ-022 ESCALATE: escalate and buzzer SHALL both be high continuously until ack; no timeout.
REQ-023 ack high in ANNOUNCE, WAIT_ACK or ESCALATE SHALL clear the active pending bit, clear active_alert, deassert buzzer/escalate, and enter IDLE next cycle.
REQ-024 ack high in IDLE SHALL be ignored.
REQ-025 Preemption: a fall_state edge while serving a non-fall alert in ANNOUNCE or WAIT_ACK SHALL abort to IDLE next cycle, leaving the aborted pending bit set; retry count discarded.
REQ-026 ESCALATE SHALL NOT be preempted.
REQ-027 Same-cycle edge and ack on the active source: set SHALL win, bit stays pending and is re-served.
REQ-028 Edge on an already-pending source SHALL have no effect.
REQ-029 Timer SHALL be 16-bit, reloaded on every state entry; retry count 4-bit, saturating never needed given MAX_RETRY range.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 On reset: state IDLE, pending 0, active_alert 0, buzzer 0, escalate 0, busy 0, timer 0, retry 0, edge registers 0.
REQ-032 Reset mid-operation SHALL abort immediately and discard all pending alerts.
REQ-033 An input held high across reset release SHALL register as an edge in the first clocked cycle.

Verification (BEEP_CYCLES=4, ACK_TIMEOUT=8, MAX_RETRY=2)
REQ-034 temp edge, ack in 2nd WAIT_ACK cycle -> pending 0100, buzzer high 4 cycles, active_alert 0100, returns IDLE, pending 0000.
REQ-035 medicine edge, no ack -> two announce/wait rounds (4 on, 8 off each), then escalate=1, buzzer=1 until ack; ack clears all.
REQ-036 bpm and medicine edges same cycle -> bpm served first; after ack medicine served; pending 1010 -> 1000 -> 0000.
REQ-037 serving medicine in WAIT_ACK, fall edge -> IDLE then fall active (0001), pending 1001; medicine re-served after fall ack.
REQ-038 in ESCALATE for temp, fall edge -> escalate stays 1, pending 0101; after ack, fall served next.
REQ-039 reset asserted during ANNOUNCE with pending 0110 -> all outputs 0 same cycle asynchronously; inputs low after release -> stays IDLE.
